frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Parametrised successor to the fixed double-buffered panel framebuffer. Holds NUM_BUFS banks (2 = double, 3 = triple buffering) of 2^ADDR_WIDTH words each, and manages writer/reader bank ownership.
- Runs entirely in the sys_clk domain. CDC from the FTDI clock is done upstream, so wr_* arrive already synchronised.
- Adds features the fixed version lacks: writer back-pressure in double mode, non-blocking triple buffering with a dropped-frame counter, exported bank indices, and a registered read-valid.

Parameters:
- DATA_WIDTH, 20, bits per pixel word.
- ADDR_WIDTH, 14, word address width per bank.
- NUM_BUFS, 2, bank count. Legal values are 2 or 3; any other value is an elaboration error.
- DROP_CNT_WIDTH, 16, width of drop_count.

Ports:
- sys_clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  DATA_WIDTH  write data.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_en  in  1  write strobe. Accepted only while wr_ready=1.
- wr_frame_done  in  1  one-cycle pulse: the current write bank holds a complete frame.
- wr_ready  out  1  writer may write. Always 1 when NUM_BUFS=3.
- frame_start  in  1  one-cycle pulse from the panel scanner at the frame boundary.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_en  in  1  read strobe.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data is valid this cycle.
- swapped  out  1  one-cycle pulse: the reader moved to a new bank.
- wr_bank  out  2  index of the bank currently owned by the writer.
- rd_bank  out  2  index of the bank currently owned by the reader.
- drop_count  out  DROP_CNT_WIDTH  completed frames discarded unread. Saturating.

Behaviour:
- Reset values:
  - wr_bank=0; rd_bank=NUM_BUFS-1; internal ready_bank=1 (triple mode only).
  - pending=0, and the double-mode state is WRITING.
  - wr_ready=1, rd_data=0, rd_valid=0, swapped=0, drop_count=0.
  - Bank contents are not reset. Reset mid-frame drops all in-flight state the same way.
- Invariant: wr_bank, rd_bank and ready_bank are always pairwise distinct. The bench asserts this every cycle.
- Writes: on wr_en && wr_ready, mem[wr_bank][wr_addr] <= wr_data. Writes with wr_ready=0 are ignored.
- Reads:
  - rd_en in cycle N captures the bank index and rd_addr.
  - In cycle N+1, rd_data = mem[captured bank][addr] and rd_valid=1.
  - rd_data holds its value while rd_en=0; rd_valid=0 in those cycles.
  - A swap in cycle N does not affect the read issued in cycle N.
- Double mode (NUM_BUFS=2), states WRITING and FULL:
  - WRITING: wr_ready=1. wr_frame_done moves to FULL on the next cycle, where wr_ready=0.
  - FULL: wr_frame_done is ignored. frame_start swaps wr_bank and rd_bank and returns to WRITING.
  - frame_start in WRITING does nothing. There is no swap, so the reader repeats its frame.
  - wr_frame_done and frame_start in the same cycle while WRITING: enter FULL, no swap. The swap happens on the next frame_start.
- Triple mode (NUM_BUFS=3):
  - wr_frame_done, frame_start inactive: swap wr_bank and ready_bank, set pending=1. If pending was already 1, also increment drop_count.
  - frame_start with pending=1, no wr_frame_done: swap rd_bank and ready_bank, clear pending=0.
  - Both in the same cycle with pending=1: rotate rd_bank<=old wr_bank, wr_bank<=old rd_bank, ready_bank unchanged, pending=0, drop_count+1.
  - Both in the same cycle with pending=0: handle wr_frame_done only, so pending becomes 1 and there is no swap.
  - frame_start with pending=0 does nothing.
- swapped: asserted for exactly one cycle, in the first cycle rd_bank shows its new value. It is never asserted without a rd_bank change.
- drop_count saturates at all-ones and does not wrap.
- Addresses: full range 0..2^ADDR_WIDTH-1. There is no address wrap logic; wr_addr and rd_addr index the bank directly.

Test Plan:
1. Double mode, reset. Write 0xABCDE to addr 5, pulse wr_frame_done, then frame_start, then read addr 5 -> wr_ready falls the cycle after wr_frame_done. swapped=1 with rd_bank=0 and wr_bank=1. rd_data=0xABCDE with rd_valid=1 one cycle after rd_en.
2. Double mode, FULL. Drive wr_en to addr 5 with 0x11111, then frame_start -> write ignored and wr_ready=0 until the swap. After the next frame, the new write bank's addr 5 is unchanged.
3. Triple mode. Three wr_frame_done pulses with no frame_start, then one frame_start -> drop_count=2. rd_bank holds the third frame, verified by a unique pattern. wr_ready stays 1 throughout.
4. Triple mode, pending=1. wr_frame_done and frame_start in the same cycle -> rd_bank=old wr_bank, wr_bank=old rd_bank, drop_count+1, swapped=1, pending=0.
5. rd_en issued in the same cycle as a swap -> returned data comes from the pre-swap bank. The next read returns data from the new bank.
6. Assert rst while in FULL with pending data -> next cycle wr_bank=0, rd_bank=NUM_BUFS-1, wr_ready=1, drop_count=0, rd_valid=0, swapped=0.

Source files
------------

// File: rtl/frame_buffer_ctrl_if.sv
// frame_buffer_ctrl_if: writer, reader and bank-status signals of frame_buffer_ctrl; master drives writes/reads, slave is the controller
interface frame_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 14,
  parameter int DROP_CNT_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic wr_en;
  logic wr_frame_done;
  logic wr_ready;
  logic frame_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic rd_valid;
  logic swapped;
  logic [1:0] wr_bank;
  logic [1:0] rd_bank;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
  modport master (
    output wr_data, wr_addr, wr_en, wr_frame_done, frame_start, rd_addr, rd_en,
    input wr_ready, rd_data, rd_valid, swapped, wr_bank, rd_bank, drop_count
  );
  modport slave (
    input wr_data, wr_addr, wr_en, wr_frame_done, frame_start, rd_addr, rd_en,
    output wr_ready, rd_data, rd_valid, swapped, wr_bank, rd_bank, drop_count
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: double/triple-buffered frame store with bank ownership; ports sys_clk, rst (sync, active-high), bus (writer, reader, bank/drop status)
module frame_buffer_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_BUFS = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input logic sys_clk,
  input logic rst,
  frame_buffer_ctrl_if.slave bus
);
  localparam int BW = $clog2(NUM_BUFS);
  localparam int DEPTH = NUM_BUFS << ADDR_WIDTH;
  typedef enum logic {WRITING, FULL} state_t;
  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_bufs
    $error("frame_buffer_ctrl: NUM_BUFS must be 2 or 3");
  end
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t r_state, w_state_n;
  logic [1:0] r_wr_bank, r_rd_bank, r_ready_bank, w_wr_n, w_rd_n, w_ready_n;
  logic r_pending, w_pend_n, w_drop_inc, w_wr_ready, r_rd_valid, r_swapped;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  assign w_wr_ready = (NUM_BUFS == 3) || (r_state == WRITING);
  always_comb begin
    w_state_n = r_state;
    w_wr_n = r_wr_bank;
    w_rd_n = r_rd_bank;
    w_ready_n = r_ready_bank;
    w_pend_n = r_pending;
    w_drop_inc = 1'b0;
    if (NUM_BUFS == 2) begin
      if (r_state == WRITING) w_state_n = bus.wr_frame_done ? FULL : WRITING;
      else if (bus.frame_start) begin
        w_state_n = WRITING;
        w_wr_n = r_rd_bank;
        w_rd_n = r_wr_bank;
      end
    end else begin
      // a simultaneous frame_start with a stale ready frame hands the just-finished frame straight to the reader
      if (bus.wr_frame_done && bus.frame_start && r_pending) begin
        w_rd_n = r_wr_bank;
        w_wr_n = r_rd_bank;
        w_pend_n = 1'b0;
        w_drop_inc = 1'b1;
      end else if (bus.wr_frame_done) begin
        w_wr_n = r_ready_bank;
        w_ready_n = r_wr_bank;
        w_pend_n = 1'b1;
        w_drop_inc = r_pending;
      end else if (bus.frame_start && r_pending) begin
        w_rd_n = r_ready_bank;
        w_ready_n = r_rd_bank;
        w_pend_n = 1'b0;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= WRITING;
      r_wr_bank <= 2'd0;
      r_rd_bank <= 2'(NUM_BUFS - 1);
      r_ready_bank <= 2'd1;
      r_pending <= 1'b0;
      r_drop <= '0;
      r_swapped <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_n;
      r_wr_bank <= w_wr_n;
      r_rd_bank <= w_rd_n;
      r_ready_bank <= w_ready_n;
      r_pending <= w_pend_n;
      r_swapped <= w_rd_n != r_rd_bank;
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= r_mem[{r_rd_bank[BW-1:0], bus.rd_addr}];
      if (w_drop_inc && !(&r_drop)) r_drop <= r_drop + 1'b1;
    end
  end
  always_ff @(posedge sys_clk)
    if (bus.wr_en && w_wr_ready) r_mem[{r_wr_bank[BW-1:0], bus.wr_addr}] <= bus.wr_data;
  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.swapped = r_swapped;
  assign bus.wr_bank = r_wr_bank;
  assign bus.rd_bank = r_rd_bank;
  assign bus.drop_count = r_drop;
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: scoreboard bench for double (d2) and triple (d3, 2-bit drop counter) instances
module tb_frame_buffer_ctrl;
  logic sys_clk, rst;
  int checks, failures;
  logic [19:0] q2[$], q3[$];
  logic [19:0] e2, e3;
  frame_buffer_ctrl_if if2 ();
  frame_buffer_ctrl_if #(.DROP_CNT_WIDTH(2)) if3 ();
  frame_buffer_ctrl d2 (.sys_clk(sys_clk), .rst(rst), .bus(if2.slave));
  frame_buffer_ctrl #(.NUM_BUFS(3), .DROP_CNT_WIDTH(2)) d3 (.sys_clk(sys_clk), .rst(rst), .bus(if3.slave));
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic idle;
    if2.wr_data = '0; if2.wr_addr = '0; if2.wr_en = 0; if2.wr_frame_done = 0; if2.frame_start = 0; if2.rd_addr = '0; if2.rd_en = 0;
    if3.wr_data = '0; if3.wr_addr = '0; if3.wr_en = 0; if3.wr_frame_done = 0; if3.frame_start = 0; if3.rd_addr = '0; if3.rd_en = 0;
  endtask
  always @(negedge sys_clk) if (!rst) begin
    checks++;
    if (if2.wr_bank === if2.rd_bank || if2.wr_bank > 2'd1 || if2.rd_bank > 2'd1) begin
      failures++; $display("FAIL d2_bank_invariant wr=%0d rd=%0d must be distinct and <2", if2.wr_bank, if2.rd_bank);
    end
    checks++;
    if (if3.wr_bank === if3.rd_bank || if3.wr_bank === d3.r_ready_bank || if3.rd_bank === d3.r_ready_bank || if3.wr_bank > 2'd2 || if3.rd_bank > 2'd2 || d3.r_ready_bank > 2'd2) begin
      failures++; $display("FAIL d3_bank_invariant wr=%0d rd=%0d ready=%0d must be distinct and <3", if3.wr_bank, if3.rd_bank, d3.r_ready_bank);
    end
    if (if2.rd_valid) begin
      checks++;
      if (q2.size() == 0) begin failures++; $display("FAIL d2_rd_unexpected got=%0h exp=none", if2.rd_data); end
      else begin
        e2 = q2.pop_front();
        if (if2.rd_data !== e2) begin failures++; $display("FAIL d2_rd_data got=%0h exp=%0h", if2.rd_data, e2); end
      end
    end
    if (if3.rd_valid) begin
      checks++;
      if (q3.size() == 0) begin failures++; $display("FAIL d3_rd_unexpected got=%0h exp=none", if3.rd_data); end
      else begin
        e3 = q3.pop_front();
        if (if3.rd_data !== e3) begin failures++; $display("FAIL d3_rd_data got=%0h exp=%0h", if3.rd_data, e3); end
      end
    end
  end
  task automatic test_reset;
    idle;
    rst = 1;
    tick;
    checks++;
    if ({if2.wr_bank, if2.rd_bank, if2.wr_ready, if2.rd_valid, if2.swapped} !== {2'd0, 2'd1, 3'b100}) begin
      failures++; $display("FAIL d2_reset_ctl got=%0d/%0d/%b%b%b exp=0/1/100", if2.wr_bank, if2.rd_bank, if2.wr_ready, if2.rd_valid, if2.swapped);
    end
    checks++;
    if (if2.rd_data !== 20'h0 || if2.drop_count !== 16'h0) begin
      failures++; $display("FAIL d2_reset_data got=%0h/%0h exp=0/0", if2.rd_data, if2.drop_count);
    end
    checks++;
    if ({if3.wr_bank, if3.rd_bank, if3.wr_ready, if3.rd_valid, if3.swapped} !== {2'd0, 2'd2, 3'b100}) begin
      failures++; $display("FAIL d3_reset_ctl got=%0d/%0d/%b%b%b exp=0/2/100", if3.wr_bank, if3.rd_bank, if3.wr_ready, if3.rd_valid, if3.swapped);
    end
    checks++;
    if (if3.rd_data !== 20'h0 || if3.drop_count !== 2'd0) begin
      failures++; $display("FAIL d3_reset_data got=%0h/%0h exp=0/0", if3.rd_data, if3.drop_count);
    end
    rst = 0;
  endtask
  task automatic test_double_basic;
    if2.wr_en = 1; if2.wr_addr = 14'd5; if2.wr_data = 20'hABCDE;
    tick;
    if2.wr_addr = 14'd7; if2.wr_data = 20'h44444;
    tick;
    if2.wr_en = 0; if2.wr_frame_done = 1;
    checks++;
    if (if2.wr_ready !== 1'b1) begin failures++; $display("FAIL d2_ready_before_done got=%b exp=1", if2.wr_ready); end
    tick;
    if2.wr_frame_done = 0;
    checks++;
    if (if2.wr_ready !== 1'b0) begin failures++; $display("FAIL d2_ready_fall got=%b exp=0", if2.wr_ready); end
    if2.frame_start = 1;
    tick;
    if2.frame_start = 0;
    checks++;
    if ({if2.swapped, if2.rd_bank, if2.wr_bank, if2.wr_ready} !== {1'b1, 2'd0, 2'd1, 1'b1}) begin
      failures++; $display("FAIL d2_first_swap got=sw%b rd%0d wr%0d rdy%b exp=sw1 rd0 wr1 rdy1", if2.swapped, if2.rd_bank, if2.wr_bank, if2.wr_ready);
    end
    if2.rd_en = 1; if2.rd_addr = 14'd5; q2.push_back(20'hABCDE);
    tick;
    if2.rd_en = 0;
    checks++;
    if (if2.swapped !== 1'b0) begin failures++; $display("FAIL d2_swap_one_cycle got=%b exp=0", if2.swapped); end
    tick;
    checks++;
    if (if2.rd_valid !== 1'b0 || if2.rd_data !== 20'hABCDE) begin
      failures++; $display("FAIL d2_rd_hold got=v%b %0h exp=v0 abcde", if2.rd_valid, if2.rd_data);
    end
  endtask
  task automatic test_double_full;
    if2.wr_en = 1; if2.wr_addr = 14'd5; if2.wr_data = 20'h22222;
    tick;
    if2.wr_addr = 14'd7; if2.wr_data = 20'h33333;
    tick;
    if2.wr_en = 0; if2.wr_frame_done = 1;
    tick;
    if2.wr_en = 1; if2.wr_addr = 14'd5; if2.wr_data = 20'h11111;
    tick;
    if2.wr_frame_done = 0;
    checks++;
    if (if2.wr_ready !== 1'b0 || if2.wr_bank !== 2'd1 || if2.rd_bank !== 2'd0) begin
      failures++; $display("FAIL d2_full_hold got=rdy%b wr%0d rd%0d exp=rdy0 wr1 rd0", if2.wr_ready, if2.wr_bank, if2.rd_bank);
    end
    if2.frame_start = 1;
    if2.rd_en = 1; if2.rd_addr = 14'd7; q2.push_back(20'h44444);
    tick;
    if2.frame_start = 0; if2.wr_en = 0;
    checks++;
    if ({if2.swapped, if2.rd_bank, if2.wr_bank, if2.wr_ready} !== {1'b1, 2'd1, 2'd0, 1'b1}) begin
      failures++; $display("FAIL d2_full_swap got=sw%b rd%0d wr%0d rdy%b exp=sw1 rd1 wr0 rdy1", if2.swapped, if2.rd_bank, if2.wr_bank, if2.wr_ready);
    end
    q2.push_back(20'h33333);
    tick;
    if2.rd_addr = 14'd5; q2.push_back(20'h22222);
    tick;
    if2.rd_en = 0; if2.wr_frame_done = 1;
    tick;
    if2.wr_frame_done = 0; if2.frame_start = 1;
    tick;
    if2.frame_start = 0;
    checks++;
    if (if2.swapped !== 1'b1 || if2.rd_bank !== 2'd0) begin
      failures++; $display("FAIL d2_second_swap got=sw%b rd%0d exp=sw1 rd0", if2.swapped, if2.rd_bank);
    end
    if2.rd_en = 1; if2.rd_addr = 14'd5; q2.push_back(20'hABCDE);
    tick;
    if2.rd_en = 0;
    tick;
  endtask
  task automatic test_double_no_swap;
    if2.frame_start = 1;
    tick;
    if2.frame_start = 0;
    checks++;
    if (if2.swapped !== 1'b0 || if2.rd_bank !== 2'd0 || if2.wr_ready !== 1'b1) begin
      failures++; $display("FAIL d2_start_in_writing got=sw%b rd%0d rdy%b exp=sw0 rd0 rdy1", if2.swapped, if2.rd_bank, if2.wr_ready);
    end
    if2.frame_start = 1; if2.wr_frame_done = 1;
    tick;
    if2.frame_start = 0; if2.wr_frame_done = 0;
    checks++;
    if (if2.swapped !== 1'b0 || if2.rd_bank !== 2'd0 || if2.wr_ready !== 1'b0) begin
      failures++; $display("FAIL d2_done_and_start got=sw%b rd%0d rdy%b exp=sw0 rd0 rdy0", if2.swapped, if2.rd_bank, if2.wr_ready);
    end
    if2.frame_start = 1;
    tick;
    if2.frame_start = 0;
    checks++;
    if (if2.swapped !== 1'b1 || if2.rd_bank !== 2'd1 || if2.wr_bank !== 2'd0) begin
      failures++; $display("FAIL d2_deferred_swap got=sw%b rd%0d wr%0d exp=sw1 rd1 wr0", if2.swapped, if2.rd_bank, if2.wr_bank);
    end
  endtask
  task automatic test_triple_drop;
    for (int i = 0; i < 3; i++) begin
      if3.wr_en = 1; if3.wr_addr = 14'd3; if3.wr_data = 20'hA0000 + 20'(i);
      tick;
      if3.wr_en = 0; if3.wr_frame_done = 1;
      tick;
      if3.wr_frame_done = 0;
      checks++;
      if (if3.wr_ready !== 1'b1 || if3.swapped !== 1'b0 || if3.rd_bank !== 2'd2) begin
        failures++; $display("FAIL d3_done_%0d got=rdy%b sw%b rd%0d exp=rdy1 sw0 rd2", i, if3.wr_ready, if3.swapped, if3.rd_bank);
      end
    end
    checks++;
    if (if3.drop_count !== 2'd2 || if3.wr_bank !== 2'd1) begin
      failures++; $display("FAIL d3_drop_two got=drop%0d wr%0d exp=drop2 wr1", if3.drop_count, if3.wr_bank);
    end
    if3.frame_start = 1;
    tick;
    if3.frame_start = 0;
    checks++;
    if (if3.swapped !== 1'b1 || if3.rd_bank !== 2'd0 || if3.drop_count !== 2'd2) begin
      failures++; $display("FAIL d3_swap got=sw%b rd%0d drop%0d exp=sw1 rd0 drop2", if3.swapped, if3.rd_bank, if3.drop_count);
    end
    if3.rd_en = 1; if3.rd_addr = 14'd3; q3.push_back(20'hA0002);
    tick;
    if3.rd_en = 0;
    tick;
  endtask
  task automatic test_triple_both;
    if3.wr_en = 1; if3.wr_addr = 14'd3; if3.wr_data = 20'hD0004;
    tick;
    if3.wr_en = 0; if3.wr_frame_done = 1;
    tick;
    if3.wr_frame_done = 0;
    if3.wr_en = 1; if3.wr_data = 20'hE0005;
    tick;
    if3.wr_en = 0; if3.wr_frame_done = 1; if3.frame_start = 1;
    if3.rd_en = 1; if3.rd_addr = 14'd3; q3.push_back(20'hA0002);
    tick;
    if3.wr_frame_done = 0; if3.frame_start = 0;
    checks++;
    if ({if3.swapped, if3.rd_bank, if3.wr_bank, if3.drop_count} !== {1'b1, 2'd2, 2'd0, 2'd3}) begin
      failures++; $display("FAIL d3_rotate got=sw%b rd%0d wr%0d drop%0d exp=sw1 rd2 wr0 drop3", if3.swapped, if3.rd_bank, if3.wr_bank, if3.drop_count);
    end
    q3.push_back(20'hE0005);
    tick;
    if3.rd_en = 0; if3.frame_start = 1;
    tick;
    if3.frame_start = 0;
    checks++;
    if (if3.swapped !== 1'b0 || if3.rd_bank !== 2'd2) begin
      failures++; $display("FAIL d3_start_no_pending got=sw%b rd%0d exp=sw0 rd2", if3.swapped, if3.rd_bank);
    end
  endtask
  task automatic test_triple_saturate;
    if3.wr_frame_done = 1; if3.frame_start = 1;
    tick;
    if3.frame_start = 0;
    checks++;
    if ({if3.swapped, if3.rd_bank, if3.wr_bank, if3.drop_count} !== {1'b0, 2'd2, 2'd1, 2'd3}) begin
      failures++; $display("FAIL d3_both_no_pending got=sw%b rd%0d wr%0d drop%0d exp=sw0 rd2 wr1 drop3", if3.swapped, if3.rd_bank, if3.wr_bank, if3.drop_count);
    end
    tick;
    if3.wr_frame_done = 0;
    checks++;
    if (if3.drop_count !== 2'd3 || if3.wr_bank !== 2'd0) begin
      failures++; $display("FAIL d3_drop_saturate got=drop%0d wr%0d exp=drop3 wr0", if3.drop_count, if3.wr_bank);
    end
  endtask
  task automatic test_reset_mid;
    if2.wr_frame_done = 1;
    tick;
    if2.wr_frame_done = 0;
    checks++;
    if (if2.wr_ready !== 1'b0) begin failures++; $display("FAIL d2_full_before_reset got=%b exp=0", if2.wr_ready); end
    test_reset;
    tick;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle;
    tick;
    test_reset;
    test_double_basic;
    test_double_full;
    test_double_no_swap;
    test_triple_drop;
    test_triple_both;
    test_triple_saturate;
    test_reset_mid;
    checks++;
    if (q2.size() != 0 || q3.size() != 0) begin
      failures++; $display("FAIL reads_outstanding got=%0d/%0d exp=0/0", q2.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
